// File: rtl/ram_sram_sequencer.sv
// ram_sram_sequencer
// Memory-clock-domain sequencer: pops one command at a time from the command
// FIFO, runs a single access on an asynchronous SRAM with programmable strobe
// widths, and pushes read results into the read-return FIFO.
//
// Optional feature macro: RAM_SEQ_DQ_IREG_EN
//   When defined, iSramDq passes through an input register before capture.
//   The read pulse is one cycle longer to cover the extra register stage.
//
// Ports
//   iMemClk, iRst        memory clock, synchronous active-high reset
//   iFifoEmp/oFifoRe     command FIFO empty flag / one-cycle pop strobe
//   iFifoRvd             command FIFO read data valid
//   iFifoWd/Adrs/Cmd     command payload (Cmd 1 = write, 0 = read)
//   oMemWd/oMemWEd       read-return data / one-cycle push strobe
//   iMemFull             read-return FIFO full (gates every pop)
//   oSramAdrs            SRAM address
//   oSramDq/oSramDqOe    SRAM write data / DQ drive enable
//   iSramDq              SRAM read data
//   oSramCeN/OeN/WeN     active-low SRAM strobes
//   oBusy                high whenever an access is in progress
module ram_sram_sequencer #(
    parameter int unsigned pRamDqWidth      = 8,
    parameter int unsigned pRamAdrsWidth    = 19,
    parameter int unsigned pWriteWaitCycles = 2,
    parameter int unsigned pReadWaitCycles  = 2
) (
    input  logic                     iMemClk,
    input  logic                     iRst,
    input  logic                     iFifoEmp,
    output logic                     oFifoRe,
    input  logic                     iFifoRvd,
    input  logic [pRamDqWidth-1:0]   iFifoWd,
    input  logic [pRamAdrsWidth-1:0] iFifoAdrs,
    input  logic                     iFifoCmd,
    output logic [pRamDqWidth-1:0]   oMemWd,
    output logic                     oMemWEd,
    input  logic                     iMemFull,
    output logic [pRamAdrsWidth-1:0] oSramAdrs,
    output logic [pRamDqWidth-1:0]   oSramDq,
    output logic                     oSramDqOe,
    input  logic [pRamDqWidth-1:0]   iSramDq,
    output logic                     oSramCeN,
    output logic                     oSramOeN,
    output logic                     oSramWeN,
    output logic                     oBusy
);

`ifdef RAM_SEQ_DQ_IREG_EN
    localparam int unsigned ReadPulseCycles = pReadWaitCycles + 1;
`else
    localparam int unsigned ReadPulseCycles = pReadWaitCycles;
`endif
    localparam int unsigned CntMax   = (pWriteWaitCycles > ReadPulseCycles) ?
                                       pWriteWaitCycles : ReadPulseCycles;
    localparam int unsigned CntWidth = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, WR_SETUP, WR_PULSE, WR_HOLD, RD_PULSE, RD_RET
    } state_t;

    state_t                   state, state_nxt;
    logic [CntWidth-1:0]      cnt, cnt_nxt;
    logic [pRamDqWidth-1:0]   rd_src;

    logic                     fifo_re_d, mem_wed_d, dq_oe_d;
    logic                     ce_n_d, oe_n_d, we_n_d, busy_d;
    logic [pRamDqWidth-1:0]   mem_wd_d, dq_d;
    logic [pRamAdrsWidth-1:0] adrs_d;

    // Read-data source: optional input register in front of the capture flop.
`ifdef RAM_SEQ_DQ_IREG_EN
    logic [pRamDqWidth-1:0] sram_dq_q;
    always_ff @(posedge iMemClk) begin
        if (iRst) sram_dq_q <= '0;
        else      sram_dq_q <= iSramDq;
    end
    assign rd_src = sram_dq_q;
`else
    assign rd_src = iSramDq;
`endif

    // State, pulse counter and registered outputs.
    always_ff @(posedge iMemClk) begin
        if (iRst) begin
            state     <= IDLE;
            cnt       <= '0;
            oFifoRe   <= 1'b0;
            oMemWEd   <= 1'b0;
            oMemWd    <= '0;
            oSramAdrs <= '0;
            oSramDq   <= '0;
            oSramDqOe <= 1'b0;
            oSramCeN  <= 1'b1;
            oSramOeN  <= 1'b1;
            oSramWeN  <= 1'b1;
            oBusy     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            oFifoRe   <= fifo_re_d;
            oMemWEd   <= mem_wed_d;
            oMemWd    <= mem_wd_d;
            oSramAdrs <= adrs_d;
            oSramDq   <= dq_d;
            oSramDqOe <= dq_oe_d;
            oSramCeN  <= ce_n_d;
            oSramOeN  <= oe_n_d;
            oSramWeN  <= we_n_d;
            oBusy     <= busy_d;
        end
    end

    // Next-state logic; the counter is loaded on entry to a pulse state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (!iFifoEmp && !iMemFull) state_nxt = FETCH;
            end
            FETCH: begin
                if (iFifoRvd) begin
                    if (iFifoCmd) begin
                        state_nxt = WR_SETUP;
                    end else begin
                        state_nxt = RD_PULSE;
                        cnt_nxt   = CntWidth'(ReadPulseCycles - 1);
                    end
                end
            end
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                cnt_nxt   = CntWidth'(pWriteWaitCycles - 1);
            end
            WR_PULSE: begin
                if (cnt == '0) state_nxt = WR_HOLD;
                else           cnt_nxt   = cnt - 1'b1;
            end
            WR_HOLD: state_nxt = IDLE;
            RD_PULSE: begin
                if (cnt == '0) state_nxt = RD_RET;
                else           cnt_nxt   = cnt - 1'b1;
            end
            RD_RET:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so the
    // registered pins line up with the state they belong to.
    always_comb begin
        fifo_re_d = 1'b0;
        mem_wed_d = 1'b0;
        mem_wd_d  = oMemWd;
        adrs_d    = oSramAdrs;
        dq_d      = oSramDq;
        dq_oe_d   = 1'b0;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        busy_d    = (state_nxt != IDLE);

        // Address and write data are latched straight from the FIFO payload.
        if (state == FETCH && iFifoRvd) begin
            adrs_d = iFifoAdrs;
            dq_d   = iFifoWd;
        end
        // Capture on the last cycle of the read pulse.
        if (state == RD_PULSE && cnt == '0) mem_wd_d = rd_src;

        case (state_nxt)
            FETCH:    fifo_re_d = (state == IDLE);
            WR_SETUP,
            WR_HOLD: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            WR_PULSE: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                we_n_d  = 1'b0;
            end
            RD_PULSE: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            RD_RET:   mem_wed_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_sram_sequencer.sv
// tb_ram_sram_sequencer
// Self-checking bench for ram_sram_sequencer. A command-level model expands
// every popped command into the cycle-by-cycle pin pattern the access must
// show, and a byte-array SRAM model answers reads from what the DUT wrote.
`timescale 1ns/1ps
module tb_ram_sram_sequencer;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 19;
    localparam int unsigned WW = 2;
    localparam int unsigned RW = 2;
`ifdef RAM_SEQ_DQ_IREG_EN
    localparam int unsigned RdPulse = RW + 1;
`else
    localparam int unsigned RdPulse = RW;
`endif

    logic          iMemClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iFifoEmp = 1'b1;
    logic          oFifoRe;
    logic          iFifoRvd = 1'b0;
    logic [DW-1:0] iFifoWd = '0;
    logic [AW-1:0] iFifoAdrs = '0;
    logic          iFifoCmd = 1'b0;
    logic [DW-1:0] oMemWd;
    logic          oMemWEd;
    logic          iMemFull = 1'b0;
    logic [AW-1:0] oSramAdrs;
    logic [DW-1:0] oSramDq;
    logic          oSramDqOe;
    logic [DW-1:0] iSramDq = '0;
    logic          oSramCeN;
    logic          oSramOeN;
    logic          oSramWeN;
    logic          oBusy;

    ram_sram_sequencer #(
        .pRamDqWidth(DW), .pRamAdrsWidth(AW),
        .pWriteWaitCycles(WW), .pReadWaitCycles(RW)
    ) dut (
        .iMemClk(iMemClk), .iRst(iRst),
        .iFifoEmp(iFifoEmp), .oFifoRe(oFifoRe), .iFifoRvd(iFifoRvd),
        .iFifoWd(iFifoWd), .iFifoAdrs(iFifoAdrs), .iFifoCmd(iFifoCmd),
        .oMemWd(oMemWd), .oMemWEd(oMemWEd), .iMemFull(iMemFull),
        .oSramAdrs(oSramAdrs), .oSramDq(oSramDq), .oSramDqOe(oSramDqOe),
        .iSramDq(iSramDq), .oSramCeN(oSramCeN), .oSramOeN(oSramOeN),
        .oSramWeN(oSramWeN), .oBusy(oBusy)
    );

    always #5 iMemClk = ~iMemClk;

    typedef struct {
        logic          cmd;
        logic [AW-1:0] adrs;
        logic [DW-1:0] wd;
        int unsigned   dly;   // cycles from the pop strobe to read-data-valid
    } cmd_t;

    // One expected cycle of pin activity.
    typedef struct {
        logic          re, ce_n, oe_n, we_n, dqoe, wed, busy;
        logic [AW-1:0] adrs;
        logic [DW-1:0] dq, rd;
        logic          fetch, rvd, wp, zero;
        logic          cmd_in;
        logic [AW-1:0] adrs_in;
        logic [DW-1:0] wd_in;
    } exp_t;

    cmd_t          fifo_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] sram    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [AW-1:0] pool [8];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    bit force_full = 0, rand_bp = 0, stray_en = 0, rst_arm = 0, post_rst = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h2C;
    endfunction

    function automatic exp_t idle_rec();
        exp_t r;
        r.re = 0; r.ce_n = 1; r.oe_n = 1; r.we_n = 1; r.dqoe = 0; r.wed = 0; r.busy = 0;
        r.adrs = '0; r.dq = '0; r.rd = '0;
        r.fetch = 0; r.rvd = 0; r.wp = 0; r.zero = 0;
        r.cmd_in = 0; r.adrs_in = '0; r.wd_in = '0;
        return r;
    endfunction

    // Expand one command into its fetch and access cycles.
    task automatic plan(input cmd_t c);
        exp_t r;
        for (int i = 0; i <= int'(c.dly); i++) begin
            r = idle_rec();
            r.busy = 1; r.fetch = 1; r.re = (i == 0);
            if (i == int'(c.dly)) begin
                r.rvd = 1; r.cmd_in = c.cmd; r.adrs_in = c.adrs; r.wd_in = c.wd;
            end
            exp_q.push_back(r);
        end
        if (c.cmd) begin
            ref_mem[c.adrs] = c.wd;
            r = idle_rec();
            r.busy = 1; r.ce_n = 0; r.dqoe = 1; r.adrs = c.adrs; r.dq = c.wd;
            exp_q.push_back(r);
            for (int i = 0; i < int'(WW); i++) begin
                r.we_n = 0; r.wp = 1;
                exp_q.push_back(r);
            end
            r.we_n = 1; r.wp = 0;
            exp_q.push_back(r);
        end else begin
            r = idle_rec();
            r.busy = 1; r.ce_n = 0; r.oe_n = 0; r.adrs = c.adrs;
            for (int i = 0; i < int'(RdPulse); i++) exp_q.push_back(r);
            r = idle_rec();
            r.busy = 1; r.wed = 1; r.rd = ref_mem[c.adrs];
            exp_q.push_back(r);
        end
    endtask

    // One clock cycle: check pins, run the SRAM model, drive the next inputs.
    task automatic step();
        exp_t e;
        bit   was_idle;
        @(negedge iMemClk);
        cyc++;
        was_idle = (exp_q.size() == 0);
        if (was_idle) e = idle_rec();
        else          e = exp_q.pop_front();
        if (was_idle && post_rst) e.zero = 1;
        post_rst = 0;

        check_eq("fifo_re", 32'(oFifoRe),   32'(e.re));
        check_eq("ce_n",    32'(oSramCeN),  32'(e.ce_n));
        check_eq("oe_n",    32'(oSramOeN),  32'(e.oe_n));
        check_eq("we_n",    32'(oSramWeN),  32'(e.we_n));
        check_eq("dq_oe",   32'(oSramDqOe), 32'(e.dqoe));
        check_eq("mem_wed", 32'(oMemWEd),   32'(e.wed));
        check_eq("busy",    32'(oBusy),     32'(e.busy));
        check_eq("bus_contention", 32'(oSramDqOe & ~oSramOeN), 32'(0));
        if (!e.ce_n || e.zero) check_eq("adrs",   32'(oSramAdrs), 32'(e.adrs));
        if (e.dqoe || e.zero)  check_eq("dq",     32'(oSramDq),   32'(e.dq));
        if (e.wed || e.zero)   check_eq("mem_wd", 32'(oMemWd),    32'(e.rd));

        if (!oSramCeN && !oSramWeN && oSramDqOe) sram[oSramAdrs] = oSramDq;
        iSramDq = (!oSramCeN && !oSramOeN) ? sram[oSramAdrs] : DW'($urandom);

        iFifoRvd  = 1'b0;
        iFifoCmd  = 1'($urandom);
        iFifoWd   = DW'($urandom);
        iFifoAdrs = AW'($urandom);
        if (e.rvd) begin
            iFifoRvd = 1'b1; iFifoCmd = e.cmd_in; iFifoWd = e.wd_in; iFifoAdrs = e.adrs_in;
        end else if (stray_en && !e.fetch && $urandom_range(0, 3) == 0) begin
            iFifoRvd = 1'b1;
        end

        if (rst_arm && e.wp) begin
            rst_arm  = 0;
            iRst     = 1'b1;
            iFifoEmp = 1'b1;
            iMemFull = 1'b0;
            exp_q.delete();
            post_rst = 1;
            return;
        end
        iRst = 1'b0;

        iMemFull = force_full || (rand_bp && $urandom_range(0, 4) == 0);
        iFifoEmp = (fifo_q.size() == 0) || (rand_bp && $urandom_range(0, 3) == 0);
        if (was_idle && !iFifoEmp && !iMemFull) plan(fifo_q.pop_front());
    endtask

    task automatic push_cmd(input logic cmd, input logic [AW-1:0] adrs,
                            input logic [DW-1:0] wd, input int unsigned dly);
        cmd_t c;
        c.cmd = cmd; c.adrs = adrs; c.wd = wd; c.dly = dly;
        fifo_q.push_back(c);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_timeout", 32'(fifo_q.size() + exp_q.size()), 32'(0));
        step();
        step();
    endtask

    initial begin
        pool = '{19'h00000, 19'h7FFFF, 19'h12345, 19'h00010,
                 19'h3A5C1, 19'h40000, 19'h0FFFF, 19'h2AAAA};
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = init_val(AW'(i));
            ref_mem[i] = sram[i];
        end
        repeat (2) @(negedge iMemClk);
        post_rst = 1;
        step();                                   // reset values

        push_cmd(1'b1, 19'h12345, 8'hA5, 0);      // single write
        drain(50);
        push_cmd(1'b0, 19'h00010, 8'h00, 0);      // single read, expects 0x3C
        drain(50);

        push_cmd(1'b1, 19'h7FFFF, 8'h5A, 0);      // write-read-write, same address
        push_cmd(1'b0, 19'h7FFFF, 8'h00, 0);
        push_cmd(1'b1, 19'h7FFFF, 8'hC3, 0);
        drain(80);

        force_full = 1;                           // backpressure holds the pop
        push_cmd(1'b0, 19'h12345, 8'h00, 1);
        repeat (6) step();
        force_full = 0;
        drain(50);

        stray_en = 1;                             // stray read-valid while idle
        repeat (8) step();
        stray_en = 0;
        push_cmd(1'b1, 19'h2AAAA, 8'h96, 4);      // slow FIFO
        push_cmd(1'b0, 19'h2AAAA, 8'h00, 4);
        drain(80);

        rst_arm = 1;                              // reset in the write pulse
        push_cmd(1'b1, 19'h55555, 8'hEE, 0);
        push_cmd(1'b0, 19'h00010, 8'h00, 1);
        drain(80);

        rand_bp = 1;
        stray_en = 1;
        for (int i = 0; i < 250; i++)
            push_cmd(1'($urandom), pool[$urandom_range(0, 7)], DW'($urandom), $urandom_range(0, 3));
        drain(250 * 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
